frame_game_ctrl: RTL and testbench



---
 rtl/frame_game_ctrl_if.sv | 29 ++
 rtl/frame_game_ctrl.sv | 140 ++++++++++++++
 tb/tb_frame_game_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_game_ctrl_if.sv
// Signal bundle between the frame game controller and its environment
// (input debouncers and pixel renderer).
interface frame_game_ctrl_if #(
    parameter int POS_W   = 9,
    parameter int VEL_W   = 6,
    parameter int SCORE_W = 8
);
    logic                      v_sync;
    logic                      flap;
    logic                      hit;
    logic                      score_evt;
    logic                      frame_tick;
    logic [POS_W-1:0]          pixel_pos;
    logic signed [VEL_W-1:0]   velocity;
    logic                      game_over;
    logic [SCORE_W-1:0]        score;

    // No valid/ready handshake here: the inputs are levels or one-cycle
    // pulses sampled every clock; the outputs are registered and always valid.
    modport master (
        input  v_sync, flap, hit, score_evt,
        output frame_tick, pixel_pos, velocity, game_over, score
    );

    modport slave (
        output v_sync, flap, hit, score_evt,
        input  frame_tick, pixel_pos, velocity, game_over, score
    );
endinterface

// File: rtl/frame_game_ctrl.sv
// Per-frame game controller: frame tick from v_sync, player physics with
// gravity/flap/clamping, IDLE/PLAY/OVER state machine and saturating score.
module frame_game_ctrl #(
    parameter int POS_W       = 9,
    parameter int POS_INIT    = 265,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 465,
    parameter int VEL_W       = 6,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = -6,
    parameter int VEL_MAX     = 7,
    parameter int SCORE_W     = 8,
    parameter int HOLD_FRAMES = 30
) (
    input  logic               clock,
    input  logic               reset,
    frame_game_ctrl_if.master  bus,
    output logic [1:0]         state_dbg
);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0]         HOLD_MAX = HOLD_W'(HOLD_FRAMES);
    localparam logic [POS_W-1:0]          POS_RST  = POS_W'(POS_INIT);
    localparam logic signed [POS_W+1:0]   NP_MIN   = (POS_W+2)'(POS_MIN);
    localparam logic signed [POS_W+1:0]   NP_MAX   = (POS_W+2)'(POS_MAX);
    localparam logic signed [VEL_W:0]     VEL_LIM  = (VEL_W+1)'(VEL_MAX);
    localparam logic signed [VEL_W:0]     GRAV_V   = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W-1:0]   FLAP_V   = VEL_W'(FLAP_VEL);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic                     vs1_q, vs1_d, vs2_q, vs2_d, tick_q, tick_d;
    logic                     flap_lvl_q, flap_lvl_d;
    logic                     flap_pend_q, flap_pend_d, hit_pend_q, hit_pend_d;
    logic [POS_W-1:0]         pixel_pos_q, pixel_pos_d;
    logic signed [VEL_W-1:0]  velocity_q, velocity_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;

    logic                     flap_rise, do_play;
    logic signed [VEL_W:0]    vel_inc;
    logic signed [VEL_W-1:0]  nv;
    logic signed [POS_W+1:0]  np;

    always_comb begin
        state_d     = state_q;
        vs1_d       = bus.v_sync;
        vs2_d       = vs1_q;
        tick_d      = vs1_q & ~vs2_q;
        flap_lvl_d  = bus.flap;
        pixel_pos_d = pixel_pos_q;
        velocity_d  = velocity_q;
        score_d     = score_q;
        hold_d      = hold_q;

        // Events landing in the tick cycle itself survive into the next frame.
        flap_rise   = bus.flap & ~flap_lvl_q;
        flap_pend_d = tick_q ? flap_rise : (flap_pend_q | flap_rise);
        hit_pend_d  = tick_q ? bus.hit : (hit_pend_q | bus.hit);

        vel_inc = (VEL_W+1)'(velocity_q) + GRAV_V;
        if (flap_pend_q)
            nv = FLAP_V;
        else if (vel_inc > VEL_LIM)
            nv = VEL_LIM[VEL_W-1:0];
        else
            nv = vel_inc[VEL_W-1:0];
        np = (POS_W+2)'(signed'({1'b0, pixel_pos_q})) + (POS_W+2)'(nv);

        do_play = tick_q && ((state_q == IDLE && flap_pend_q) || state_q == PLAY);

        if (state_q == PLAY && bus.score_evt && score_q != '1)
            score_d = score_q + 1'b1;

        if (state_q == OVER && tick_q) begin
            if (flap_pend_q && hold_q == HOLD_MAX) begin
                state_d     = IDLE;
                pixel_pos_d = POS_RST;
                velocity_d  = '0;
                score_d     = '0;
                hold_d      = '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
        end

        if (do_play) begin
            state_d = PLAY;
            // A pending hit wins: freeze the pre-tick position and drop the flap.
            if (hit_pend_q) begin
                state_d = OVER;
            end else if (np < NP_MIN) begin
                pixel_pos_d = POS_W'(POS_MIN);
                velocity_d  = '0;
            end else if (np >= NP_MAX) begin
                pixel_pos_d = POS_W'(POS_MAX);
                velocity_d  = '0;
                state_d     = OVER;
            end else begin
                pixel_pos_d = np[POS_W-1:0];
                velocity_d  = nv;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            vs1_q       <= 1'b0;
            vs2_q       <= 1'b0;
            tick_q      <= 1'b0;
            flap_lvl_q  <= 1'b0;
            flap_pend_q <= 1'b0;
            hit_pend_q  <= 1'b0;
            pixel_pos_q <= POS_RST;
            velocity_q  <= '0;
            score_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            tick_q      <= tick_d;
            flap_lvl_q  <= flap_lvl_d;
            flap_pend_q <= flap_pend_d;
            hit_pend_q  <= hit_pend_d;
            pixel_pos_q <= pixel_pos_d;
            velocity_q  <= velocity_d;
            score_q     <= score_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.frame_tick = tick_q;
    assign bus.pixel_pos  = pixel_pos_q;
    assign bus.velocity   = velocity_q;
    assign bus.game_over  = (state_q == OVER);
    assign bus.score      = score_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_frame_game_ctrl.sv
// Directed self-checking bench for frame_game_ctrl, with a second instance
// built at SCORE_W=4 sharing the same stimulus for score saturation.
module tb_frame_game_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    frame_game_ctrl_if #(.POS_W(9), .VEL_W(6), .SCORE_W(8)) bus ();
    frame_game_ctrl_if #(.POS_W(9), .VEL_W(6), .SCORE_W(4)) bus4 ();
    logic [1:0] state_dbg, state_dbg4;

    frame_game_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    frame_game_ctrl #(.SCORE_W(4)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus4.master),
        .state_dbg (state_dbg4)
    );

    assign bus4.v_sync    = bus.v_sync;
    assign bus4.flap      = bus.flap;
    assign bus4.hit       = bus.hit;
    assign bus4.score_evt = bus.score_evt;

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clock);
        if (bus.frame_tick === 1'b1) tick_cnt++;
    endtask

    task automatic frame();
        bus.v_sync = 1'b1;
        step();
        step();
        bus.v_sync = 1'b0;
        repeat (4) step();
    endtask

    task automatic press_flap();
        bus.flap = 1'b1;
        step();
        bus.flap = 1'b0;
        step();
    endtask

    task automatic pulse_hit();
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        step();
    endtask

    task automatic pulse_score();
        bus.score_evt = 1'b1;
        step();
        bus.score_evt = 1'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        n_vec++; if (bus.pixel_pos !== 9'd265) begin n_err++; $display("FAIL reset_pos got %0d exp 265", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'sd0) begin n_err++; $display("FAIL reset_vel got %0d exp 0", bus.velocity); end
        n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL reset_over got %b exp 0", bus.game_over); end
        n_vec++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL reset_score got %0d exp 0", bus.score); end
        n_vec++; if (bus.frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b exp 0", bus.frame_tick); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_idle_ticks();
        tick_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            frame();
            n_vec++; if (tick_cnt !== i + 1) begin n_err++; $display("FAIL idle_tick_count got %0d exp %0d", tick_cnt, i + 1); end
        end
        n_vec++; if (bus.pixel_pos !== 9'd265) begin n_err++; $display("FAIL idle_pos got %0d exp 265", bus.pixel_pos); end
        n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL idle_over got %b exp 0", bus.game_over); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL idle_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_flap_from_idle();
        int ev[3] = '{-6, -5, -4};
        int ep[3] = '{259, 254, 250};
        press_flap();
        for (int i = 0; i < 3; i++) begin
            frame();
            n_vec++; if (bus.velocity !== 6'(ev[i])) begin n_err++; $display("FAIL flap_vel[%0d] got %0d exp %0d", i, bus.velocity, ev[i]); end
            n_vec++; if (bus.pixel_pos !== 9'(ep[i])) begin n_err++; $display("FAIL flap_pos[%0d] got %0d exp %0d", i, bus.pixel_pos, ep[i]); end
        end
        n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL flap_state got %0d exp 1", state_dbg); end
    endtask

    task automatic test_score();
        repeat (3) pulse_score();
        n_vec++; if (bus.score !== 8'd3) begin n_err++; $display("FAIL score3 got %0d exp 3", bus.score); end
        n_vec++; if (bus4.score !== 4'd3) begin n_err++; $display("FAIL score3_w4 got %0d exp 3", bus4.score); end
    endtask

    task automatic test_hit_restart();
        pulse_hit();
        frame();
        n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL hit_over got %b exp 1", bus.game_over); end
        n_vec++; if (bus.pixel_pos !== 9'd250) begin n_err++; $display("FAIL hit_pos got %0d exp 250", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'(-4)) begin n_err++; $display("FAIL hit_vel got %0d exp -4", bus.velocity); end
        pulse_score();
        n_vec++; if (bus.score !== 8'd3) begin n_err++; $display("FAIL over_score got %0d exp 3", bus.score); end
        repeat (9) frame();
        press_flap();
        frame();
        n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL early_flap10 got %b exp 1", bus.game_over); end
        repeat (19) frame();
        press_flap();
        frame();
        n_vec++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL early_flap29 got %b exp 1", bus.game_over); end
        press_flap();
        frame();
        n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL restart_over got %b exp 0", bus.game_over); end
        n_vec++; if (bus.pixel_pos !== 9'd265) begin n_err++; $display("FAIL restart_pos got %0d exp 265", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'sd0) begin n_err++; $display("FAIL restart_vel got %0d exp 0", bus.velocity); end
        n_vec++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL restart_score got %0d exp 0", bus.score); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL restart_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_score_saturate();
        press_flap();
        frame();
        repeat (20) pulse_score();
        n_vec++; if (bus.score !== 8'd20) begin n_err++; $display("FAIL score20 got %0d exp 20", bus.score); end
        n_vec++; if (bus4.score !== 4'd15) begin n_err++; $display("FAIL score_sat_w4 got %0d exp 15", bus4.score); end
    endtask

    task automatic test_ceiling();
        // Starting at (259, -6): 43 more flaps reach 1, the 44th would go to -5.
        for (int k = 0; k < 44; k++) begin
            press_flap();
            frame();
            if (k == 42) begin
                n_vec++; if (bus.pixel_pos !== 9'd1) begin n_err++; $display("FAIL ceil_pre_pos got %0d exp 1", bus.pixel_pos); end
            end
        end
        n_vec++; if (bus.pixel_pos !== 9'd0) begin n_err++; $display("FAIL ceil_pos got %0d exp 0", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'sd0) begin n_err++; $display("FAIL ceil_vel got %0d exp 0", bus.velocity); end
        n_vec++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL ceil_state got %0d exp 1", state_dbg); end
        frame();
        n_vec++; if (bus.pixel_pos !== 9'd1) begin n_err++; $display("FAIL ceil_fall_pos got %0d exp 1", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'sd1) begin n_err++; $display("FAIL ceil_fall_vel got %0d exp 1", bus.velocity); end
    endtask

    task automatic test_vsync_long();
        tick_cnt = 0;
        bus.v_sync = 1'b1;
        repeat (20) step();
        bus.v_sync = 1'b0;
        repeat (4) step();
        n_vec++; if (tick_cnt !== 1) begin n_err++; $display("FAIL long_vsync_ticks got %0d exp 1", tick_cnt); end
        n_vec++; if (bus.pixel_pos !== 9'd3) begin n_err++; $display("FAIL long_vsync_pos got %0d exp 3", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'sd2) begin n_err++; $display("FAIL long_vsync_vel got %0d exp 2", bus.velocity); end
    endtask

    task automatic test_reset_mid_play();
        repeat (5) pulse_score();
        n_vec++; if (bus.score !== 8'd25) begin n_err++; $display("FAIL pre_reset_score got %0d exp 25", bus.score); end
        reset = 1'b0;
        step();
        n_vec++; if (bus.pixel_pos !== 9'd265) begin n_err++; $display("FAIL midrst_pos got %0d exp 265", bus.pixel_pos); end
        n_vec++; if (bus.velocity !== 6'sd0) begin n_err++; $display("FAIL midrst_vel got %0d exp 0", bus.velocity); end
        n_vec++; if (bus.score !== 8'd0) begin n_err++; $display("FAIL midrst_score got %0d exp 0", bus.score); end
        n_vec++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL midrst_over got %b exp 0", bus.game_over); end
        n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL midrst_state got %0d exp 0", state_dbg); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_gravity_floor();
        int p = 259;
        int v = -6;
        int nv, np, vmax;
        logic over = 1'b0;
        vmax = v;
        press_flap();
        frame();
        n_vec++; if (bus.pixel_pos !== 9'(p) || bus.velocity !== 6'(v)) begin n_err++; $display("FAIL fall_start got %0d/%0d exp %0d/%0d", bus.pixel_pos, bus.velocity, p, v); end
        for (int f = 0; f < 100 && !over; f++) begin
            nv = (v + 1 > 7) ? 7 : v + 1;
            np = p + nv;
            if (np >= 465) begin p = 465; v = 0; over = 1'b1; end
            else begin p = np; v = nv; end
            if (v > vmax) vmax = v;
            frame();
            n_vec++; if (bus.pixel_pos !== 9'(p) || bus.velocity !== 6'(v) || bus.game_over !== over) begin
                n_err++; $display("FAIL fall[%0d] got %0d/%0d/%b exp %0d/%0d/%b", f, bus.pixel_pos, bus.velocity, bus.game_over, p, v, over);
            end
        end
        n_vec++; if (!over || vmax != 7) begin n_err++; $display("FAIL floor_reached got over=%b vmax=%0d exp over=1 vmax=7", over, vmax); end
        n_vec++; if (bus.pixel_pos !== 9'd465 || bus.game_over !== 1'b1) begin n_err++; $display("FAIL floor_clamp got %0d/%b exp 465/1", bus.pixel_pos, bus.game_over); end
    endtask

    initial begin
        bus.v_sync    = 1'b0;
        bus.flap      = 1'b0;
        bus.hit       = 1'b0;
        bus.score_evt = 1'b0;
        test_reset();
        test_idle_ticks();
        test_flap_from_idle();
        test_score();
        test_hit_restart();
        test_score_saturate();
        test_ceiling();
        test_vsync_long();
        test_reset_mid_play();
        test_gravity_floor();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
